// File: rtl/wbbootmem_arbiter.sv
// wbbootmem_arbiter
//   Shares the single-port boot memory between two Wishbone masters
//   (m0 = instruction bus, m1 = data bus / loader).
//   - Round-robin grant, held for the owner's whole bus cycle (cyc).
//   - Registered grant: a request seen in cycle t reaches the slave in t+1.
//   - Per-access ack timeout: after TIMEOUT strobe cycles without an ack the
//     owner gets a one-cycle err and the strobe is withdrawn for that cycle.
//
// Ports
//   wb_clk_i, wb_rst_n_i          clock, async active-low reset
//   mN_adr/dat/we/sel/cyc/stb_i   master N request (N = 0,1)
//   mN_dat/ack/err_o              master N response
//   s_adr/dat/we/sel/cyc/stb_o    request to slave, muxed from owner
//   s_dat_i, s_ack_i              response from slave
module wbbootmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i
);

    localparam int         SW   = DW / 8;
    localparam logic [7:0] TLIM = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t     state, state_nxt;
    logic       last, last_nxt;     // most recently granted master
    logic [7:0] tcnt, tcnt_nxt;
    logic       err_q, err_nxt;
    logic       gnt_new;            // first cycle of a fresh grant

    // Master request buses gathered so the owner can be selected by index.
    logic [1:0][AW-1:0] adr;
    logic [1:0][DW-1:0] wdat;
    logic [1:0][SW-1:0] sel;
    logic [1:0]         we, cyc, stb;
    logic               own;
    logic               ack_v;

    assign adr  = {m1_adr_i, m0_adr_i};
    assign wdat = {m1_dat_i, m0_dat_i};
    assign sel  = {m1_sel_i, m0_sel_i};
    assign we   = {m1_we_i,  m0_we_i};
    assign cyc  = {m1_cyc_i, m0_cyc_i};
    assign stb  = {m1_stb_i, m0_stb_i};
    assign own  = (state == OWN1);

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state   <= IDLE;
            last    <= 1'b1;
            tcnt    <= 8'd0;
            err_q   <= 1'b0;
            gnt_new <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            tcnt    <= tcnt_nxt;
            err_q   <= err_nxt;
            gnt_new <= (state_nxt != state) && (state_nxt != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_nxt = last ? OWN0 : OWN1;
                else if (m0_cyc_i)        state_nxt = OWN0;
                else if (m1_cyc_i)        state_nxt = OWN1;
            end
            OWN0:    if (!m0_cyc_i) state_nxt = m1_cyc_i ? OWN1 : IDLE;
            OWN1:    if (!m1_cyc_i) state_nxt = m0_cyc_i ? OWN0 : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == OWN0 && state != OWN0) last_nxt = 1'b0;
        if (state_nxt == OWN1 && state != OWN1) last_nxt = 1'b1;
    end

    // An ack in the first cycle of a grant belongs to the previous owner's
    // access (the slave registers its ack), so it is dropped.
    assign ack_v = s_ack_i & ~gnt_new;

    // Output logic
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (state != IDLE) begin
            s_adr_o = adr[own];
            s_dat_o = wdat[own];
            s_we_o  = we[own];
            s_sel_o = sel[own];
            s_cyc_o = cyc[own];
            s_stb_o = stb[own] & ~err_q;
        end
    end

    assign m0_ack_o = (state == OWN0) & ack_v;
    assign m1_ack_o = (state == OWN1) & ack_v;
    assign m0_err_o = (state == OWN0) & err_q;
    assign m1_err_o = (state == OWN1) & err_q;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Timeout: counts strobe cycles without ack. Any ack, the err cycle
    // itself, an owner change or IDLE restarts the count from zero. Ack in
    // the limit cycle suppresses the err.
    always_comb begin
        tcnt_nxt = 8'd0;
        err_nxt  = 1'b0;
        if (TIMEOUT != 0 && state != IDLE && state_nxt == state &&
            s_stb_o && !ack_v) begin
            if (tcnt == TLIM) err_nxt  = 1'b1;
            else              tcnt_nxt = tcnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_wbbootmem_arbiter.sv
module tb_wbbootmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
    logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
    logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        s_we, s_cyc, s_stb, s_ack;

    // Bench slave: registered ack one cycle after a strobe, never back to back
    logic        model_en, ack_tie0, tb_ack, mem_load;
    logic        mdl_ack;
    logic [31:0] mdl_dat;
    logic [31:0] mem [16];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign s_ack = model_en ? mdl_ack : tb_ack;

    function automatic logic [31:0] fw(input int i);
        return 32'hF00D_0000 + 32'(i * 32'h0111);
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= fw(i);
            mdl_ack <= 1'b0;
            mdl_dat <= '0;
        end else if (model_en && s_cyc && s_stb && !mdl_ack && !ack_tie0) begin
            mdl_ack <= 1'b1;
            mdl_dat <= mem[s_adr[5:2]];
            if (s_we)
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) mem[s_adr[5:2]][8*b +: 8] <= s_wdat[8*b +: 8];
        end else begin
            mdl_ack <= 1'b0;
        end
    end

    wbbootmem_arbiter dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(mdl_dat), .s_ack_i(s_ack)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle vector: inputs c0 s0 c1 s1 ack | expected s_cyc s_stb owner a0 a1
    // owner: 0 none (s_adr=0), 1 m0 (0x100), 2 m1 (0x200)
    typedef struct packed {
        logic       c0, s0, c1, s1, ack;
        logic       scyc, sstb;
        logic [1:0] own;
        logic       a0, a1;
    } vec_t;

    vec_t vt [15];

    logic        other_ack;

    // Runs one access on master m; called #1 after a rising edge.
    task automatic access(input int m, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] sel,
                          output logic [31:0] rd, output logic got);
        if (m == 0) begin
            m0_adr = a; m0_wdat = d; m0_we = we; m0_sel = sel; m0_cyc = 1; m0_stb = 1;
        end else begin
            m1_adr = a; m1_wdat = d; m1_we = we; m1_sel = sel; m1_cyc = 1; m1_stb = 1;
        end
        got = 1'b0;
        rd  = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            other_ack |= (m == 0) ? m1_ack : m0_ack;
            if ((m == 0) ? m0_ack : m1_ack) begin
                got = 1'b1;
                rd  = (m == 0) ? m0_rdat : m1_rdat;
            end
        end
        if (m == 0) begin m0_cyc = 0; m0_stb = 0; m0_we = 0; end
        else        begin m1_cyc = 0; m1_stb = 0; m1_we = 0; end
    endtask

    initial begin
        logic [31:0] rd, exp_w, ow;
        logic        got, m0seen, anyack;
        int          acks, n;

        vt[0]  = 11'b00000_00_00_00;
        vt[1]  = 11'b11110_00_00_00;  // tie from IDLE, last=1 -> m0 next
        vt[2]  = 11'b11110_11_01_00;
        vt[3]  = 11'b11111_11_01_10;
        vt[4]  = 11'b00110_00_01_00;  // m0 drops cyc -> m1 next
        vt[5]  = 11'b00111_11_10_00;  // late ack in new grant's first cycle dropped
        vt[6]  = 11'b00111_11_10_01;
        vt[7]  = 11'b11111_11_10_01;  // no preemption
        vt[8]  = 11'b11000_00_10_00;
        vt[9]  = 11'b11001_11_01_00;
        vt[10] = 11'b00000_00_01_00;
        vt[11] = 11'b11110_00_00_00;  // tie, last=0 -> m1 next
        vt[12] = 11'b00110_11_10_00;
        vt[13] = 11'b00000_00_10_00;
        vt[14] = 11'b00001_00_00_00;  // ack in IDLE reaches nobody

        rst_n = 0; mem_load = 1; model_en = 0; ack_tie0 = 0; tb_ack = 1;
        m0_adr = 32'h100; m0_wdat = 0; m0_we = 0; m0_sel = 4'hF; m0_cyc = 0; m0_stb = 0;
        m1_adr = 32'h200; m1_wdat = 0; m1_we = 0; m1_sel = 4'hF; m1_cyc = 0; m1_stb = 0;
        other_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_s_adr", s_adr, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_errs", {m0_err, m1_err}, 0);
        @(negedge clk);
        rst_n = 1; mem_load = 0; tb_ack = 0;

        // Table-driven cycle vectors, slave ack driven directly
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            {m0_cyc, m0_stb, m1_cyc, m1_stb, tb_ack} =
                {vt[i].c0, vt[i].s0, vt[i].c1, vt[i].s1, vt[i].ack};
            #1;
            ow = (vt[i].own == 2'd1) ? 32'h100 : (vt[i].own == 2'd2) ? 32'h200 : 32'h0;
            chk($sformatf("v%0d_s_cyc", i), s_cyc, vt[i].scyc);
            chk($sformatf("v%0d_s_stb", i), s_stb, vt[i].sstb);
            chk($sformatf("v%0d_s_adr", i), s_adr, ow);
            chk($sformatf("v%0d_m0_ack", i), m0_ack, vt[i].a0);
            chk($sformatf("v%0d_m1_ack", i), m1_ack, vt[i].a1);
            chk($sformatf("v%0d_errs", i), {m0_err, m1_err}, 0);
        end
        @(negedge clk);
        {m0_cyc, m0_stb, m1_cyc, m1_stb, tb_ack} = 5'b0;
        model_en = 1;
        repeat (2) @(posedge clk);
        #1;

        // m0 reads adr 4: strobe the cycle after request, ack the one after
        m0_adr = 32'h4; m0_cyc = 1; m0_stb = 1;
        #0;
        chk("rd_stb_before_grant", s_stb, 0);
        @(posedge clk); #1;
        chk("rd_stb_after_grant", s_stb, 1);
        chk("rd_no_early_ack", m0_ack, 0);
        @(posedge clk); #1;
        chk("rd_m0_ack", m0_ack, 1);
        chk("rd_m0_data", m0_rdat, fw(1));
        chk("rd_m1_ack_quiet", m1_ack, 0);
        m0_cyc = 0; m0_stb = 0;
        @(posedge clk); #1;

        // m0 partial write then m1 read of the same word
        other_ack = 0;
        access(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'b0011, rd, got);
        chk("wr_m0_ack", got, 1);
        access(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, got);
        chk("rd_m1_ack", got, 1);
        exp_w = fw(2);
        exp_w[15:0] = 16'hBEEF;
        chk("rd_m1_merged", rd, exp_w);
        chk("wr_rd_cross_ack", other_ack, 0);
        @(posedge clk); #1;

        // m1 holds cyc over 4 accesses while m0 waits
        m1_adr = 32'h20; m1_cyc = 1; m1_stb = 1;
        @(posedge clk); #1;
        m0_adr = 32'h10; m0_cyc = 1; m0_stb = 1;
        acks = 0; m0seen = 0;
        for (int i = 0; i < 40 && acks < 4; i++) begin
            @(posedge clk); #1;
            if (m1_ack) acks++;
            m0seen |= m0_ack | (s_adr != 32'h20);
        end
        chk("lock_m1_acks", acks, 4);
        chk("lock_m0_held_off", m0seen, 0);
        m1_cyc = 0; m1_stb = 0;
        @(posedge clk); #1;
        chk("lock_m0_granted_adr", s_adr, 32'h10);
        chk("lock_m0_granted_stb", s_stb, 1);
        m0_cyc = 0; m0_stb = 0;
        repeat (2) @(posedge clk);
        #1;

        // Timeout with a dead slave
        ack_tie0 = 1;
        m0_cyc = 1; m0_stb = 1;
        @(posedge clk); #1;
        n = 0; anyack = 0;
        while (!m0_err && n < 40) begin
            if (s_stb) n++;
            anyack |= m0_ack;
            @(posedge clk); #1;
        end
        chk("to_stb_cycles", n, 16);
        chk("to_m0_err", m0_err, 1);
        chk("to_stb_dropped", s_stb, 0);
        chk("to_m1_err", m1_err, 0);
        @(posedge clk); #1;
        chk("to_err_one_cycle", m0_err, 0);
        chk("to_stb_restart", s_stb, 1);
        chk("to_no_ack", anyack, 0);
        m0_cyc = 0; m0_stb = 0; ack_tie0 = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while the slave ack is pending
        m0_adr = 32'h0; m0_cyc = 1; m0_stb = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pending_ack_seen", s_ack, 1);
        rst_n = 0;
        #1;
        chk("rst_mid_m0_ack", m0_ack, 0);
        chk("rst_mid_errs", {m0_err, m1_err}, 0);
        chk("rst_mid_s_cyc", s_cyc, 0);
        chk("rst_mid_s_stb", s_stb, 0);
        m0_cyc = 0; m0_stb = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("rst_after_idle", s_cyc, 0);
        m0_cyc = 1; m0_stb = 1;
        #0;
        chk("rst_restart_idle_stb", s_stb, 0);
        @(posedge clk); #1;
        chk("rst_restart_grant", s_stb, 1);
        m0_cyc = 0; m0_stb = 0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
